// File: rtl/mux_scan_pkg.sv
// Shared types and scan-order helpers for the 4:1 mux scan sequencer.
// MUX_SCAN_GRAY_EN selects Gray scan order (0,1,3,2) instead of binary.
package mux_scan_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_DONE
    } state_t;

    typedef struct packed {
        logic            found;
        logic [SELW-1:0] pos;
    } nxt_t;

    // Map a scan position to the channel (select value) visited there.
    function automatic logic [SELW-1:0] scan_ch(input logic [SELW-1:0] pos);
`ifdef MUX_SCAN_GRAY_EN
        return pos ^ (pos >> 1);
`else
        return pos;
`endif
    endfunction

    // Lowest scan position >= from whose channel is enabled in mask.
    function automatic nxt_t next_enabled(input logic [NCH-1:0] mask, input logic [SELW:0] from);
        nxt_t r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if ((SELW + 1)'(i) >= from && mask[scan_ch(SELW'(i))]) begin
                r.found = 1'b1;
                r.pos   = SELW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_dwell_ctr.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps, flags the last dwell cycle.
// Latency: tc is combinational from the registered count; no backpressure.
module mux_scan_dwell_ctr #(
    parameter int DWELL = 2,
    parameter int CW    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans enabled mux channels, holds each select DWELL cycles, captures y into sample.
// Latency: frame_done N*DWELL edges after the start edge; no backpressure (start ignored while busy).
// Optional MUX_SCAN_GRAY_EN: Gray scan order via mux_scan_pkg::scan_ch.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int CW    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           cont,
    input  logic [NCH-1:0] ch_mask,
    input  logic           y_in,
    output logic           s0,
    output logic           s1,
    output logic           busy,
    output logic [NCH-1:0] sample,
    output logic           frame_done
);

    state_t          state_q, state_d;
    logic [SELW-1:0] pos_q, pos_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            busy_q, busy_d;
    logic [NCH-1:0]  sample_q, sample_d;
    logic            frame_done_q, frame_done_d;
    logic            tc;
    nxt_t            n_start, n_next;

    mux_scan_dwell_ctr #(.DWELL(DWELL), .CW(CW)) u_ctr (
        .clk (clk),
        .rst (rst),
        .clr (state_q != S_DWELL),
        .en  (state_q == S_DWELL),
        .tc  (tc)
    );

    assign n_start = next_enabled(ch_mask, '0);
    assign n_next  = next_enabled(mask_q, {1'b0, pos_q} + (SELW + 1)'(1));

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        mask_d       = mask_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        sample_d     = sample_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE with cont relaunches exactly like a start from IDLE
                if ((state_q == S_IDLE && start) || (state_q == S_DONE && cont)) begin
                    mask_d   = ch_mask;
                    sample_d = '0;
                    if (n_start.found) begin
                        state_d = S_DWELL;
                        pos_d   = n_start.pos;
                        sel_d   = scan_ch(n_start.pos);
                        busy_d  = 1'b1;
                    end else begin
                        state_d      = S_DONE;
                        sel_d        = '0;
                        frame_done_d = 1'b1;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_DWELL: begin
                if (tc) begin
                    sample_d[scan_ch(pos_q)] = y_in;
                    if (n_next.found) begin
                        pos_d = n_next.pos;
                        sel_d = scan_ch(n_next.pos);
                    end else begin
                        state_d      = S_DONE;
                        sel_d        = '0;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pos_q        <= '0;
            mask_q       <= '0;
            sel_q        <= '0;
            busy_q       <= 1'b0;
            sample_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            mask_q       <= mask_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            sample_q     <= sample_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s0         = sel_q[0];
    assign s1         = sel_q[1];
    assign busy       = busy_q;
    assign sample     = sample_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: a tiny mux model feeds y_in from the selects.
module tb_mux_scan_sequencer;

    localparam int D = 2;

    typedef struct {
        logic [3:0] smp;
        logic       bsy;
        int         cyc;
    } frm_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] ch_mask = 4'b0000;
    logic [3:0] yvec = 4'b0000;
    logic       y_in;
    logic       s0, s1, busy, frame_done;
    logic [3:0] sample;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [1:0] sq[$];
    frm_t       fq[$];

`ifdef MUX_SCAN_GRAY_EN
    int order[4] = '{0, 1, 3, 2};
`else
    int order[4] = '{0, 1, 2, 3};
`endif

    mux_scan_sequencer #(.DWELL(D), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cont       (cont),
        .ch_mask    (ch_mask),
        .y_in       (y_in),
        .s0         (s0),
        .s1         (s1),
        .busy       (busy),
        .sample     (sample),
        .frame_done (frame_done)
    );

    assign y_in = yvec[{s1, s0}];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected selects for each dwell cycle, plus the frame record at frame_done.
    task automatic push_exp(input logic [3:0] m, input logic [3:0] exp_s, input logic exp_b,
                            input int edge_n, output int n);
        frm_t f;
        n = 0;
        for (int p = 0; p < 4; p++) begin
            if (m[order[p]]) begin
                for (int k = 0; k < D; k++) sq.push_back(2'(order[p]));
                n++;
            end
        end
        f.smp = exp_s;
        f.bsy = exp_b;
        f.cyc = edge_n + n * D;
        fq.push_back(f);
    endtask

    task automatic run_frame(input logic [3:0] m, input logic [3:0] yv, input logic [3:0] exp_s,
                             input logic exp_b, input bit poke_start);
        int n;
        @(negedge clk);
        yvec = yv;
        ch_mask = m;
        start = 1'b1;
        push_exp(m, exp_s, exp_b, cyc + 1, n);
        @(negedge clk);
        start = 1'b0;
        ch_mask = ~m;
        if (poke_start) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (n * D + 3) @(negedge clk);
    endtask

    initial begin : monitor
        frm_t f;
        forever begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                if (fq.size() == 0) begin
                    check("frame_unexpected", frame_done, 0);
                end else begin
                    f = fq.pop_front();
                    check("frame_sample", sample, f.smp);
                    check("frame_busy", busy, f.bsy);
                    check("frame_cycle", cyc, f.cyc);
                end
            end else if (busy) begin
                if (sq.size() == 0) check("busy_extra", busy, 0);
                else check("sel_seq", {s1, s0}, sq.pop_front());
            end else begin
                check("sel_idle", {s1, s0}, 2'b00);
            end
        end
    end

    initial begin : stim
        int n, e;
        // Reset held with start asserted: reset must win.
        start = 1'b1;
        ch_mask = 4'b1111;
        repeat (2) @(negedge clk);
        check("rst_sel", {s1, s0}, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_sample", sample, 4'b0000);
        check("rst_done", frame_done, 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
        run_frame(4'b1111, 4'b1101, 4'b1101, 1'b1, 1'b0);
        run_frame(4'b1010, 4'b1111, 4'b1010, 1'b1, 1'b1);
        run_frame(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0);

        // Continuous: mask change mid-frame lands on the next frame only.
        @(negedge clk);
        cont = 1'b1;
        yvec = 4'b0001;
        ch_mask = 4'b0011;
        start = 1'b1;
        e = cyc + 1;
        push_exp(4'b0011, 4'b0001, 1'b1, e, n);
        push_exp(4'b1100, 4'b1000, 1'b1, e + n * D + 1, n);
        @(negedge clk);
        start = 1'b0;
        ch_mask = 4'b1100;
        repeat (4) @(negedge clk);
        yvec = 4'b1000;
        repeat (3) @(negedge clk);
        cont = 1'b0;
        repeat (6) @(negedge clk);

        // Abort: reset lands on the third edge after start.
        @(negedge clk);
        yvec = 4'b0001;
        ch_mask = 4'b1111;
        start = 1'b1;
        sq.push_back(2'(order[0]));
        sq.push_back(2'(order[0]));
        sq.push_back(2'(order[1]));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_sel", {s1, s0}, 2'b00);
        check("abort_busy", busy, 0);
        check("abort_sample", sample, 4'b0000);
        check("abort_done", frame_done, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        check("sel_queue_left", sq.size(), 0);
        check("frame_queue_left", fq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
